partition_cmd_sequencer: RTL and testbench
==========================================

// Module: partition_cmd_sequencer
// PURPOSE
//  Upstream issue stage for the partition core. Buffers partition commands (PNEW/PSPLIT/PMERGE/PDISCOVER)
//  in a small FIFO, drives the core's op/operand bus one command at a time, waits for op_done, and returns
//  one response per command carrying the result module id, the mu-cost delta and an error code.
// PARAMETERS
//  FIFO_DEPTH     4   command FIFO entries; power of two, >=2
//  REGION_WIDTH   32  region/mask width; equals the core's REGION_WIDTH
//  MU_WIDTH       16  mu counter width; equals the core's MU_WIDTH
//  TIMEOUT_CYC    15  cycles in WAIT without op_done before a timeout error
// PORTS
//  clk             in   1   clock
//  rst_n           in   1   reset, asynchronous, active-low
//  cmd_valid       in   1   command offered
//  cmd_ready       out  1   FIFO not full
//  cmd_op          in   3   0 NOP,1 PNEW,2 PSPLIT,3 PMERGE,4 PDISCOVER,5-7 illegal
//  cmd_a           in   8   PSPLIT module id / PMERGE m1
//  cmd_b           in   8   PMERGE m2
//  cmd_region      in   RW  PNEW region / PSPLIT mask
//  core_op         out  3   to core op
//  core_op_valid   out  1   to core op_valid; single-cycle pulse
//  core_region     out  RW  to core pnew_region and psplit_mask
//  core_a          out  8   to core psplit_module_id and pmerge_m1
//  core_b          out  8   to core pmerge_m2
//  core_op_done    in   1   from core op_done
//  core_result_id  in   8   from core result_module_id
//  core_mu_cost    in   MW  from core mu_cost
//  rsp_valid       out  1   response available
//  rsp_ready       in   1   response accepted
//  rsp_module_id   out  8   core_result_id sampled at op_done
//  rsp_mu_delta    out  MW  mu cost consumed by this command
//  rsp_err         out  2   0 OK, 1 ILLEGAL, 2 TIMEOUT, 3 BUDGET
// BEHAVIOUR
//  - Reset: every output 0 except cmd_ready=1; FIFO emptied; FSM in IDLE. Reset mid-command aborts it
//    with no response; the core is reset by the same rst_n.
//  - Enqueue on cmd_valid&&cmd_ready. A full FIFO holds cmd_ready=0. Simultaneous push/pop when full is
//    not allowed, because ready is registered on the full flag.
//  - FSM IDLE->ISSUE when the FIFO is non-empty and no response is pending (rsp_valid=0). ISSUE pops the head.
//    - NOP: go to RESP with err=0, delta=0, id=0.
//    - Opcode 5-7: go to RESP with err=1; the core is never pulsed.
//    - Otherwise: latch operands onto core_* and snapshot mu0=core_mu_cost, pulse core_op_valid for exactly
//      one cycle, then go to WAIT.
//  - Operands stay stable from the pulse until op_done. core_op_valid must not be high when the core returns
//    to its idle state, otherwise the core re-triggers.
//  - WAIT: on core_op_done, capture id=core_result_id and delta=core_mu_cost-mu0 (modulo 2^MU_WIDTH,
//    wrap-safe), then go to RESP.
//  - WAIT timeout: a counter expires after TIMEOUT_CYC cycles. Then go to RESP with err=2, delta=0.
//  - Nominal latency: core_op_valid at cycle t, core_op_done at t+3, rsp_valid at t+4.
//  - RESP: rsp_valid held, fields stable, until rsp_ready; then go to IDLE. Back-to-back commands need one
//    IDLE cycle between them.
//  - The block never reorders commands. Exactly one response per dequeued command.
// CONFIGURATION
//  - MU_BUDGET_EN defined: extra input mu_budget [MU_WIDTH-1:0]. In ISSUE, a non-NOP legal command with
//    core_mu_cost >= mu_budget is not issued; it responds err=3, delta=0, and later commands are still
//    processed.
//  - MU_BUDGET_EN undefined: no port, no check; err=3 is never produced.
// STRUCTURE
//  - partition_pkg: opcode localparams (OP_NOP..OP_PDISCOVER), error codes (ERR_OK/ILLEGAL/TIMEOUT/BUDGET),
//    FSM state encoding, and a packed command struct {op,a,b,region}.
//  - One sub-module: partition_cmd_fifo. Synchronous, FIFO_DEPTH x (3+8+8+REGION_WIDTH), with full/empty.
//    Pointers are one bit wider than the address.
// TESTING
//  - PNEW region=0x0000_000F, core mu 0->4, rsp_ready=1 -> rsp id=0, delta=4, err=0, rsp_valid 4 cycles after the pulse.
//  - 5 PNEWs pushed back-to-back with FIFO_DEPTH=4 -> cmd_ready drops once full; 5 in-order responses, ids 0..4.
//  - cmd_op=6 -> rsp err=1, core_op_valid never asserted. NOP -> err=0, delta=0.
//  - Stub core never returns op_done -> err=2 after 15 WAIT cycles; the next command issues normally.
//  - mu0=0xFFFE, core returns 0x0006 -> delta=8. rsp_ready held low 10 cycles -> fields stable, no new issue.
//  - MU_BUDGET_EN, mu_budget=8, core mu=8, PMERGE -> err=3, no pulse. Reset asserted in WAIT -> all outputs 0, cmd_ready=1.

Source files
------------

// File: rtl/partition_pkg.sv
// Shared opcodes, error codes, FSM encoding and command record for the partition command sequencer.
package partition_pkg;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_PNEW      = 3'd1;
    localparam logic [2:0] OP_PSPLIT    = 3'd2;
    localparam logic [2:0] OP_PMERGE    = 3'd3;
    localparam logic [2:0] OP_PDISCOVER = 3'd4;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_BUDGET  = 2'd3;

    // Region field width of the buffered command record; matches the core's region bus.
    localparam int CMD_REGION_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } seq_state_t;

    typedef struct packed {
        logic [2:0]                  op;
        logic [7:0]                  a;
        logic [7:0]                  b;
        logic [CMD_REGION_WIDTH-1:0] region;
    } cmd_t;

    function automatic logic is_legal(input logic [2:0] op);
        return op <= OP_PDISCOVER;
    endfunction

endpackage

// File: rtl/partition_cmd_fifo.sv
// Small synchronous command FIFO; pointers carry an extra wrap bit to tell full from empty.
module partition_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 51
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset: empty pointers make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/partition_cmd_sequencer.sv
// Issue stage for the partition core: buffers commands, pulses the core once per command, returns one response each.
// Optional MU_BUDGET_EN adds a mu_budget input that refuses commands once the core's mu cost reaches the budget.
module partition_cmd_sequencer
    import partition_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int REGION_WIDTH = 32,
    parameter int MU_WIDTH     = 16,
    parameter int TIMEOUT_CYC  = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_op,
    input  logic [7:0]              cmd_a,
    input  logic [7:0]              cmd_b,
    input  logic [REGION_WIDTH-1:0] cmd_region,
    output logic [2:0]              core_op,
    output logic                    core_op_valid,
    output logic [REGION_WIDTH-1:0] core_region,
    output logic [7:0]              core_a,
    output logic [7:0]              core_b,
    input  logic                    core_op_done,
    input  logic [7:0]              core_result_id,
    input  logic [MU_WIDTH-1:0]     core_mu_cost,
`ifdef MU_BUDGET_EN
    input  logic [MU_WIDTH-1:0]     mu_budget,
`endif
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [7:0]              rsp_module_id,
    output logic [MU_WIDTH-1:0]     rsp_mu_delta,
    output logic [1:0]              rsp_err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] CNT_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_CYC - 1);

    seq_state_t          state;
    cmd_t                push_word;
    cmd_t                head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                over_budget;
    logic [MU_WIDTH-1:0] mu0;
    logic [TW-1:0]       wait_cnt;

    assign push_word = '{op: cmd_op, a: cmd_a, b: cmd_b, region: CMD_REGION_WIDTH'(cmd_region)};
    assign cmd_ready = !fifo_full;

`ifdef MU_BUDGET_EN
    assign over_budget = (core_mu_cost >= mu_budget);
`else
    assign over_budget = 1'b0;
`endif

    partition_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(cmd_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid),
        .push_data (push_word),
        .pop       (state == ST_ISSUE),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The pulse is dropped on the first WAIT cycle, so it is never high when the core goes idle again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            core_op       <= '0;
            core_op_valid <= 1'b0;
            core_region   <= '0;
            core_a        <= '0;
            core_b        <= '0;
            mu0           <= '0;
            wait_cnt      <= '0;
            rsp_valid     <= 1'b0;
            rsp_module_id <= '0;
            rsp_mu_delta  <= '0;
            rsp_err       <= ERR_OK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty && !rsp_valid)
                        state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (head.op == OP_NOP || !is_legal(head.op) || over_budget) begin
                        rsp_module_id <= '0;
                        rsp_mu_delta  <= '0;
                        rsp_err       <= (head.op == OP_NOP) ? ERR_OK :
                                         !is_legal(head.op)  ? ERR_ILLEGAL : ERR_BUDGET;
                        rsp_valid     <= 1'b1;
                        state         <= ST_RESP;
                    end else begin
                        core_op       <= head.op;
                        core_a        <= head.a;
                        core_b        <= head.b;
                        core_region   <= REGION_WIDTH'(head.region);
                        mu0           <= core_mu_cost;
                        core_op_valid <= 1'b1;
                        wait_cnt      <= '0;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    core_op_valid <= 1'b0;
                    if (core_op_done) begin
                        rsp_module_id <= core_result_id;
                        rsp_mu_delta  <= core_mu_cost - mu0;
                        rsp_err       <= ERR_OK;
                        rsp_valid     <= 1'b1;
                        state         <= ST_RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        rsp_module_id <= '0;
                        rsp_mu_delta  <= '0;
                        rsp_err       <= ERR_TIMEOUT;
                        rsp_valid     <= 1'b1;
                        state         <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_partition_cmd_sequencer.sv
// Scoreboard bench for partition_cmd_sequencer with a small stub core answering three cycles after each pulse.
module tb_partition_cmd_sequencer;
    import partition_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [31:0] cmd_region;
    logic [2:0]  core_op;
    logic        core_op_valid;
    logic [31:0] core_region;
    logic [7:0]  core_a;
    logic [7:0]  core_b;
    logic        core_op_done;
    logic [7:0]  core_result_id;
    logic [15:0] core_mu_cost;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_module_id;
    logic [15:0] rsp_mu_delta;
    logic [1:0]  rsp_err;
`ifdef MU_BUDGET_EN
    logic [15:0] mu_budget;
`endif

    typedef struct {
        logic [7:0]  id;
        logic [15:0] delta;
        logic [1:0]  err;
    } rsp_t;

    rsp_t        expQ[$];
    int          errors = 0;
    int          checks = 0;
    int          expId;
    logic [15:0] expMu;
    logic [15:0] muBase;
    logic [15:0] muStep;
    logic        stubMute;
    logic [15:0] muAcc;
    logic [7:0]  idCnt;
    logic [1:0]  stubCnt;
    int          cycle = 0;
    int          pulseCount = 0;
    int          lastPulse = 0;
    int          rspCycle = 0;
    logic        prevValid = 1'b0;
    logic        doublePulse = 1'b0;

    always #5 clk = ~clk;

    partition_cmd_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_a          (cmd_a),
        .cmd_b          (cmd_b),
        .cmd_region     (cmd_region),
        .core_op        (core_op),
        .core_op_valid  (core_op_valid),
        .core_region    (core_region),
        .core_a         (core_a),
        .core_b         (core_b),
        .core_op_done   (core_op_done),
        .core_result_id (core_result_id),
        .core_mu_cost   (core_mu_cost),
`ifdef MU_BUDGET_EN
        .mu_budget      (mu_budget),
`endif
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_module_id  (rsp_module_id),
        .rsp_mu_delta   (rsp_mu_delta),
        .rsp_err        (rsp_err)
    );

    assign core_mu_cost = muBase + muAcc;

    // Stub core: op_done three cycles after the pulse, mu advances by muStep, ids count up from 0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stubCnt        <= 2'd0;
            core_op_done   <= 1'b0;
            muAcc          <= 16'd0;
            idCnt          <= 8'd0;
            core_result_id <= 8'd0;
        end else begin
            core_op_done <= 1'b0;
            if (core_op_valid && !stubMute) begin
                stubCnt <= 2'd2;
            end else if (stubCnt != 2'd0) begin
                stubCnt <= stubCnt - 2'd1;
                if (stubCnt == 2'd1) begin
                    core_op_done   <= 1'b1;
                    muAcc          <= muAcc + muStep;
                    core_result_id <= idCnt;
                    idCnt          <= idCnt + 8'd1;
                end
            end
        end
    end

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (core_op_valid) begin
            pulseCount <= pulseCount + 1;
            lastPulse  <= cycle;
            if (prevValid)
                doublePulse <= 1'b1;
        end
        prevValid <= core_op_valid;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        checkOutput({tag, "_core"}, {11'd0, core_op_valid, core_op, core_a, core_b, rsp_valid}, 32'd0);
        checkOutput({tag, "_region"}, core_region, 32'd0);
        checkOutput({tag, "_rsp"}, {6'd0, rsp_module_id, rsp_mu_delta, rsp_err}, 32'd0);
    endtask

    task automatic applyReset(input string tag);
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkIdle(tag);
        expQ.delete();
        expId = 0;
        expMu = muBase;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Predicts the response from the bench's own view of the core, then offers the command.
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic [31:0] region);
        rsp_t e;
        bit   ok = 0;
        e.id    = 8'd0;
        e.delta = 16'd0;
        if (op == OP_NOP)
            e.err = ERR_OK;
        else if (op > OP_PDISCOVER)
            e.err = ERR_ILLEGAL;
`ifdef MU_BUDGET_EN
        else if (expMu >= mu_budget)
            e.err = ERR_BUDGET;
`endif
        else if (stubMute)
            e.err = ERR_TIMEOUT;
        else begin
            e.id    = expId[7:0];
            e.delta = muStep;
            e.err   = ERR_OK;
            expId++;
            expMu   = expMu + muStep;
        end
        expQ.push_back(e);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_region = region;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            checkOutput("cmd_ready_wait", 32'd0, 32'd1);
            void'(expQ.pop_back());
        end
        cmd_valid = 1'b0;
    endtask

    task automatic expectRsp(input string tag, input int holdCycles);
        rsp_t e;
        bit   seen = 0;
        int   p;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checkOutput({tag, "_valid"}, 32'd0, 32'd1);
        end else if (expQ.size() == 0) begin
            checkOutput({tag, "_unexpected"}, 32'd1, 32'd0);
        end else begin
            rspCycle = cycle;
            e = expQ.pop_front();
            checkOutput({tag, "_id"}, 32'(rsp_module_id), 32'(e.id));
            checkOutput({tag, "_delta"}, 32'(rsp_mu_delta), 32'(e.delta));
            checkOutput({tag, "_err"}, 32'(rsp_err), 32'(e.err));
            p = pulseCount;
            for (int i = 0; i < holdCycles; i++) begin
                @(negedge clk);
                checkOutput({tag, "_hold"}, {5'd0, rsp_valid, rsp_module_id, rsp_mu_delta, rsp_err},
                            {5'd0, 1'b1, e.id, e.delta, e.err});
            end
            if (holdCycles > 0)
                checkOutput({tag, "_no_issue"}, pulseCount, p);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        int  p;
        bit  sawRsp;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 3'd0;
        cmd_a      = 8'd0;
        cmd_b      = 8'd0;
        cmd_region = 32'd0;
        rsp_ready  = 1'b0;
        muBase     = 16'd0;
        muStep     = 16'd4;
        stubMute   = 1'b0;
`ifdef MU_BUDGET_EN
        mu_budget  = 16'hFFFF;
`endif
        applyReset("reset");

        // Single PNEW with nominal latency and operands held on the bus.
        applyStimulus(OP_PNEW, 8'd0, 8'd0, 32'h0000_000F);
        expectRsp("pnew", 0);
        checkOutput("pnew_latency", 32'(rspCycle - lastPulse), 32'd4);
        checkOutput("pnew_region", core_region, 32'h0000_000F);
        checkOutput("pnew_op", 32'(core_op), 32'(OP_PNEW));

        // Five back-to-back PNEWs: FIFO fills while the first response is pending.
        applyReset("reset_burst");
        muStep = 16'd1;
        for (int i = 0; i < 5; i++)
            applyStimulus(OP_PNEW, 8'd0, 8'd0, 32'(i + 1));
        @(negedge clk);
        checkOutput("burst_full_ready", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 5; i++)
            expectRsp("burst", 0);

        // Illegal opcode and NOP never touch the core.
        p = pulseCount;
        applyStimulus(3'd6, 8'd1, 8'd2, 32'd0);
        expectRsp("illegal", 0);
        applyStimulus(OP_NOP, 8'd0, 8'd0, 32'd0);
        expectRsp("nop", 0);
        checkOutput("illegal_nop_no_pulse", pulseCount, p);

        // Silent core: timeout, then the next command still issues.
        stubMute = 1'b1;
        applyStimulus(OP_PSPLIT, 8'd3, 8'd0, 32'h0000_00F0);
        expectRsp("timeout", 0);
        checkOutput("timeout_latency", 32'(rspCycle - lastPulse), 32'd15);
        stubMute = 1'b0;
        applyStimulus(OP_PDISCOVER, 8'd0, 8'd0, 32'd0);
        expectRsp("after_timeout", 0);

        // Wrapping mu counter and a stalled response with a queued command behind it.
        muBase = 16'hFFFE;
        muStep = 16'd8;
        applyReset("reset_wrap");
        applyStimulus(OP_PNEW, 8'd0, 8'd0, 32'h0000_0003);
        applyStimulus(OP_PSPLIT, 8'd0, 8'd0, 32'h0000_0001);
        expectRsp("wrap", 10);
        expectRsp("wrap_next", 0);

`ifdef MU_BUDGET_EN
        // Budget reached: refused without a pulse, later commands proceed.
        muBase    = 16'd8;
        mu_budget = 16'd8;
        applyReset("reset_budget");
        p = pulseCount;
        applyStimulus(OP_PMERGE, 8'd1, 8'd2, 32'd0);
        expectRsp("budget", 0);
        checkOutput("budget_no_pulse", pulseCount, p);
        mu_budget = 16'hFFFF;
        applyStimulus(OP_PMERGE, 8'd1, 8'd2, 32'd0);
        expectRsp("budget_next", 0);
`endif

        // Reset while waiting on the core aborts the command without a response.
        muBase   = 16'd0;
        stubMute = 1'b1;
        applyStimulus(OP_PMERGE, 8'd5, 8'd6, 32'h1234_5678);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (core_op_valid)
                break;
        end
        repeat (3) @(negedge clk);
        applyReset("reset_wait");
        stubMute = 1'b0;
        sawRsp   = 0;
        repeat (25) begin
            @(negedge clk);
            if (rsp_valid)
                sawRsp = 1;
        end
        checkOutput("no_rsp_after_reset", 32'(sawRsp), 32'd0);

        checkOutput("single_cycle_pulse", 32'(doublePulse), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
